combo_lock_ctrl: RTL



---
 rtl/combo_lock_ctrl_pkg.sv | 26 ++
 rtl/combo_lock_ctrl_lockout_timer.sv | 28 ++
 rtl/combo_lock_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/combo_lock_ctrl_pkg.sv
// Shared definitions for the combination-lock controller and the display driver.
package combo_lock_ctrl_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CODE_W  = 16;
   localparam int unsigned TRIES_W = 3;
   localparam int unsigned DCNT_W  = 3;

   localparam logic [STATE_W-1:0] S_LOCKED   = 3'd0;
   localparam logic [STATE_W-1:0] S_ENTRY    = 3'd1;
   localparam logic [STATE_W-1:0] S_UNLOCKED = 3'd2;
   localparam logic [STATE_W-1:0] S_PROGRAM  = 3'd3;
   localparam logic [STATE_W-1:0] S_HALT     = 3'd4;

   // Status codes rendered by the display stage on disp0
   localparam logic [DIGIT_W-1:0] ST_L = 4'h0;
   localparam logic [DIGIT_W-1:0] ST_U = 4'h1;
   localparam logic [DIGIT_W-1:0] ST_H = 4'h2;

   function automatic logic [CODE_W-1:0] shift_digit(input logic [CODE_W-1:0] b,
                                                     input logic [DIGIT_W-1:0] d);
      return {b[CODE_W-DIGIT_W-1:0], d};
   endfunction

endpackage

// File: rtl/combo_lock_ctrl_lockout_timer.sv
// Lockout dwell counter: load to LOCK_CYCLES-1, count down while enabled, flag zero.
module lockout_timer #(
   parameter int unsigned LOCK_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done_c
);

   localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [CNT_W-1:0] lock_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_cnt <= '0;
      end else if (load) begin
         lock_cnt <= CNT_W'(LOCK_CYCLES - 1);
      end else if (en && (lock_cnt != '0)) begin
         lock_cnt <= lock_cnt - CNT_W'(1);
      end
   end

   assign done_c = (lock_cnt == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock FSM: digit entry, code compare/program, lockout, display nibbles.
module combo_lock_ctrl
   import combo_lock_ctrl_pkg::*;
#(
   parameter logic [15:0] CODE_INIT   = 16'h1234,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCK_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digitIn,
   input  logic       enter,
   input  logic       clear,
   input  logic       relock,
   input  logic       progEn,
   output logic [3:0] disp3,
   output logic [3:0] disp2,
   output logic [3:0] disp1,
   output logic [3:0] disp0,
   output logic       statusMode,
   output logic       unlocked,
   output logic       alarm
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CODE_W-1:0]  buf_q, buf_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
   logic [TRIES_W-1:0] tries_q, tries_d;
   logic               load_c;
   logic               done_c;
   logic [CODE_W-1:0]  entry_word_c;
   logic [TRIES_W-1:0] tries_inc_c;
   logic               last_digit_c;
   logic [CODE_W-1:0]  disp_d;
   logic               status_d;

   assign entry_word_c = shift_digit(buf_q, digitIn);
   assign tries_inc_c  = (tries_q >= TRIES_W'(MAX_TRIES)) ? tries_q : tries_q + TRIES_W'(1);
   assign last_digit_c = (dcnt_q == DCNT_W'(3));

   lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (load_c),
      .en     (state_q == S_HALT),
      .done_c (done_c)
   );

   // Next-state logic; clear outranks enter, which outranks relock
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      dcnt_d  = dcnt_q;
      tries_d = tries_q;
      code_d  = code_q;
      load_c  = 1'b0;
      case (state_q)
         S_LOCKED: begin
            if (!clear && enter) begin
               buf_d   = entry_word_c;
               dcnt_d  = DCNT_W'(1);
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (clear) begin
               buf_d   = '0;
               dcnt_d  = '0;
               state_d = S_LOCKED;
            end else if (enter) begin
               if (last_digit_c) begin
                  buf_d  = '0;
                  dcnt_d = '0;
                  if (entry_word_c == code_q) begin
                     tries_d = '0;
                     state_d = S_UNLOCKED;
                  end else begin
                     tries_d = tries_inc_c;
                     if (tries_inc_c == TRIES_W'(MAX_TRIES)) begin
                        load_c  = 1'b1;
                        state_d = S_HALT;
                     end else begin
                        state_d = S_LOCKED;
                     end
                  end
               end else begin
                  buf_d  = entry_word_c;
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
         end
         S_UNLOCKED: begin
            if (clear) begin
               state_d = S_UNLOCKED;
            end else if (enter) begin
               if (progEn) begin
                  buf_d   = entry_word_c;
                  dcnt_d  = DCNT_W'(1);
                  state_d = S_PROGRAM;
               end
            end else if (relock) begin
               state_d = S_LOCKED;
            end
         end
         S_PROGRAM: begin
            if (clear || !progEn) begin
               buf_d   = '0;
               dcnt_d  = '0;
               state_d = S_UNLOCKED;
            end else if (enter) begin
               if (last_digit_c) begin
                  code_d  = entry_word_c;
                  buf_d   = '0;
                  dcnt_d  = '0;
                  state_d = S_UNLOCKED;
               end else begin
                  buf_d  = entry_word_c;
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
         end
         S_HALT: begin
            if (done_c) begin
               tries_d = '0;
               state_d = S_LOCKED;
            end
         end
         default: begin
            buf_d   = '0;
            dcnt_d  = '0;
            state_d = S_LOCKED;
         end
      endcase
   end

   // Display payload for the upcoming state, registered below
   always_comb begin
      disp_d   = '0;
      status_d = 1'b1;
      case (state_d)
         S_ENTRY, S_PROGRAM: begin
            disp_d   = buf_d;
            status_d = 1'b0;
         end
         S_UNLOCKED: disp_d = {12'h000, ST_U};
         S_HALT:     disp_d = {12'h000, ST_H};
         default:    disp_d = {12'h000, ST_L};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_LOCKED;
         buf_q      <= '0;
         code_q     <= CODE_INIT;
         dcnt_q     <= '0;
         tries_q    <= '0;
         disp3      <= '0;
         disp2      <= '0;
         disp1      <= '0;
         disp0      <= ST_L;
         statusMode <= 1'b1;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         code_q     <= code_d;
         dcnt_q     <= dcnt_d;
         tries_q    <= tries_d;
         disp3      <= disp_d[15:12];
         disp2      <= disp_d[11:8];
         disp1      <= disp_d[7:4];
         disp0      <= disp_d[3:0];
         statusMode <= status_d;
         unlocked   <= (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
         alarm      <= (state_d == S_HALT);
      end
   end

endmodule
